// File: rtl/jtl_pulse_scheduler_pkg.sv
// Shared types for the JTL pulse scheduler: FSM state encoding and the
// requester-index width helper.
package jtl_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } state_t;

   // Index width for n requesters; never narrower than one bit.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/jtl_pulse_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping past the top index.
module rr_arbiter
   import jtl_sched_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = id_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  idx,
   output logic             any
);

   logic [ID_W-1:0] cand;

   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = ID_W'((int'(ptr) + i) % N_REQ);
         if (!any && req[cand]) begin
            any       = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/jtl_pulse_scheduler.sv
// Time-shares one JTL delay line among N_REQ requesters: inject one pulse,
// time its return in clock cycles, then hold off before the next injection.
module jtl_pulse_scheduler
   import jtl_sched_pkg::*;
#(
   parameter  int N_REQ   = 4,
   parameter  int CNT_W   = 6,
   parameter  int TIMEOUT = 63,
   parameter  int HOLDOFF = 3,
   localparam int ID_W    = id_w(N_REQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  req,
   output logic [N_REQ-1:0]  grant,
   output logic              jtl_in,
   input  logic              jtl_out,
   output logic              done,
   output logic [ID_W-1:0]   done_id,
   output logic [CNT_W-1:0]  delay_cnt,
   output logic              timeout,
   output logic              stray,
   output logic              busy
);

   localparam int HOLD_W = $clog2(HOLDOFF + 1);

   state_t            state, state_nxt;
   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   cur_id;
   logic [CNT_W-1:0]  cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [N_REQ-1:0]  arb_gnt;
   logic [ID_W-1:0]   arb_idx;
   logic              arb_any;
   logic              hit;
   logic              expire;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req (req),
      .ptr (ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // A returning pulse beats the timeout when both land in the same cycle.
   always_comb begin
      state_nxt = state;
      hit       = 1'b0;
      expire    = 1'b0;
      case (state)
         IDLE: if (arb_any) state_nxt = FIRE;
         FIRE: state_nxt = WAIT;
         WAIT: begin
            if (jtl_out) begin
               hit       = 1'b1;
               state_nxt = HOLD;
            end else if (cnt == CNT_W'(TIMEOUT)) begin
               expire    = 1'b1;
               state_nxt = HOLD;
            end
         end
         HOLD: if (hold_cnt == HOLD_W'(HOLDOFF)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant     <= '0;
         jtl_in    <= 1'b0;
         done      <= 1'b0;
         done_id   <= '0;
         delay_cnt <= '0;
         timeout   <= 1'b0;
         stray     <= 1'b0;
         ptr       <= '0;
         cur_id    <= '0;
         cnt       <= '0;
         hold_cnt  <= '0;
      end else begin
         grant  <= '0;
         jtl_in <= 1'b0;
         done   <= 1'b0;
         stray  <= jtl_out && (state != WAIT);
         if (state == IDLE && arb_any) begin
            grant  <= arb_gnt;
            jtl_in <= 1'b1;
            cur_id <= arb_idx;
         end
         if (state == FIRE) begin
            cnt <= CNT_W'(1);
            ptr <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);
         end
         if (state == WAIT && !hit && !expire) cnt <= cnt + CNT_W'(1);
         if (hit || expire) begin
            done      <= 1'b1;
            done_id   <= cur_id;
            delay_cnt <= hit ? cnt : CNT_W'(TIMEOUT);
            timeout   <= expire;
            hold_cnt  <= HOLD_W'(1);
         end
         if (state == HOLD) hold_cnt <= hold_cnt + HOLD_W'(1);
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_jtl_pulse_scheduler.sv
// Bench for jtl_pulse_scheduler: timestamp-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_jtl_pulse_scheduler;

   localparam int N_REQ   = 4;
   localparam int CNT_W   = 6;
   localparam int TIMEOUT = 63;
   localparam int HOLDOFF = 3;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  grant;
   logic        jtl_in;
   logic        jtl_out;
   logic        done;
   logic [1:0]  done_id;
   logic [5:0]  delay_cnt;
   logic        timeout;
   logic        stray;
   logic        busy;

   jtl_pulse_scheduler #(
      .N_REQ   (N_REQ),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT),
      .HOLDOFF (HOLDOFF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .grant     (grant),
      .jtl_in    (jtl_in),
      .jtl_out   (jtl_out),
      .done      (done),
      .done_id   (done_id),
      .delay_cnt (delay_cnt),
      .timeout   (timeout),
      .stray     (stray),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int t = 0;

   // Reference model: a measurement is described by its FIRE cycle stamp;
   // the scheduler is idle again from a known cycle stamp onward.
   bit   m_meas;
   int   m_fire;
   int   m_idle_from;
   int   m_ptr;
   int   m_id;
   logic [3:0] e_grant;
   logic       e_jtl_in, e_done, e_timeout, e_stray, e_busy;
   logic [1:0] e_done_id;
   logic [5:0] e_delay;

   int  jtl_at   = 0;
   int  plan_dly = 0;
   bit  rnd_mode = 0;
   bit  auto_rel = 1;

   task automatic chk(input string nm, input int act, input int exp);
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, t, act, exp);
      end
   endtask

   task automatic model_edge();
      logic [3:0] r;
      bit j, rs;
      int idx;
      r   = req;
      j   = jtl_out;
      rs  = rst_n;
      idx = -1;
      e_grant  = '0;
      e_jtl_in = 1'b0;
      e_done   = 1'b0;
      e_stray  = 1'b0;
      if (!rs) begin
         m_meas      = 0;
         m_idle_from = t + 1;
         m_ptr       = 0;
         e_done_id   = '0;
         e_delay     = '0;
         e_timeout   = 1'b0;
         jtl_at      = 0;
      end else begin
         if (m_meas && t > m_fire) begin
            if (j || (t - m_fire) == TIMEOUT) begin
               e_done      = 1'b1;
               e_done_id   = 2'(m_id);
               e_delay     = j ? 6'(t - m_fire) : 6'(TIMEOUT);
               e_timeout   = !j;
               m_meas      = 0;
               m_idle_from = t + HOLDOFF + 1;
            end
         end else if (j) begin
            e_stray = 1'b1;
         end
         if (!m_meas && t >= m_idle_from && r != 4'b0) begin
            for (int k = 0; k < N_REQ; k++)
               if (idx < 0 && r[(m_ptr + k) % N_REQ]) idx = (m_ptr + k) % N_REQ;
            e_grant[idx] = 1'b1;
            e_jtl_in     = 1'b1;
            m_id         = idx;
            m_ptr        = (idx + 1) % N_REQ;
            m_fire       = t + 1;
            m_meas       = 1;
            if (rnd_mode)          jtl_at = m_fire + $urandom_range(1, 70);
            else if (plan_dly > 0) jtl_at = m_fire + plan_dly;
            else                   jtl_at = 0;
         end
      end
      e_busy = m_meas || (t + 1 < m_idle_from);
   endtask

   task automatic apply();
      if (auto_rel) req = req & ~e_grant;
      jtl_out = (jtl_at != 0) && (t + 1 == jtl_at);
      if (rnd_mode) begin
         for (int i = 0; i < N_REQ; i++)
            if ($urandom_range(0, 7) == 0) req[i] = 1'b1;
         if ($urandom_range(0, 63) == 0) req[$urandom_range(0, 3)] = 1'b0;
         if ($urandom_range(0, 39) == 0) jtl_out = 1'b1;
         rst_n = ($urandom_range(0, 499) != 0);
      end
   endtask

   task automatic step();
      @(posedge clk);
      t++;
      model_edge();
      #1;
      n_vec++;
      chk("grant",     int'(grant),     int'(e_grant));
      chk("jtl_in",    int'(jtl_in),    int'(e_jtl_in));
      chk("done",      int'(done),      int'(e_done));
      chk("done_id",   int'(done_id),   int'(e_done_id));
      chk("delay_cnt", int'(delay_cnt), int'(e_delay));
      chk("timeout",   int'(timeout),   int'(e_timeout));
      chk("stray",     int'(stray),     int'(e_stray));
      chk("busy",      int'(busy),      int'(e_busy));
      apply();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   int gr_val[5];
   int ng;
   int last_done;

   initial begin
      rst_n   = 1'b0;
      req     = 4'b0;
      jtl_out = 1'b0;
      idle(2);
      chk("rst_busy",    int'(busy), 0);
      chk("rst_grant",   int'(grant), 0);
      chk("rst_done_id", int'(done_id), 0);
      chk("rst_delay",   int'(delay_cnt), 0);
      rst_n = 1'b1;
      idle(2);

      // Single requester, pulse returns 5 cycles after FIRE, then a HOLD stray.
      plan_dly = 5;
      req = 4'b0001;
      step();
      chk("t1_grant", int'(grant), 1);
      chk("t1_jtl_in", int'(jtl_in), 1);
      idle(5);
      chk("t1_no_done_early", int'(done), 0);
      step();
      chk("t1_done", int'(done), 1);
      chk("t1_delay", int'(delay_cnt), 5);
      chk("t1_timeout", int'(timeout), 0);
      chk("t1_done_id", int'(done_id), 0);
      jtl_out = 1'b1;
      step();
      chk("t4_hold_stray", int'(stray), 1);
      chk("t4_hold_no_done", int'(done), 0);
      idle(8);

      // All requesters held high: strict rotation with hold-off spacing.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      auto_rel  = 0;
      plan_dly  = 2;
      req       = 4'b1111;
      ng        = 0;
      last_done = -100;
      for (int i = 0; i < 200 && ng < 5; i++) begin
         step();
         if (done) last_done = t;
         if (grant != 4'b0) begin
            gr_val[ng] = int'(grant);
            if (ng > 0) chk("t2_gap", int'((t - last_done) >= HOLDOFF + 1), 1);
            ng++;
         end
      end
      req = 4'b0;
      auto_rel = 1;
      chk("t2_grant_count", ng, 5);
      chk("t2_g0", gr_val[0], 1);
      chk("t2_g1", gr_val[1], 2);
      chk("t2_g2", gr_val[2], 4);
      chk("t2_g3", gr_val[3], 8);
      chk("t2_g4", gr_val[4], 1);
      idle(12);

      // No returning pulse: timeout after 63 WAIT cycles, then HOLD and IDLE.
      plan_dly = 0;
      req = 4'b0001;
      step();
      idle(63);
      chk("t3_no_done_early", int'(done), 0);
      step();
      chk("t3_done", int'(done), 1);
      chk("t3_delay", int'(delay_cnt), 63);
      chk("t3_timeout", int'(timeout), 1);
      chk("t3_busy_hold", int'(busy), 1);
      idle(2);
      chk("t3_busy_last_hold", int'(busy), 1);
      step();
      chk("t3_busy_idle", int'(busy), 0);
      idle(2);

      // Pulse returns exactly on the timeout cycle: measurement wins.
      plan_dly = 63;
      req = 4'b0001;
      step();
      idle(64);
      chk("t4_done", int'(done), 1);
      chk("t4_delay", int'(delay_cnt), 63);
      chk("t4_timeout", int'(timeout), 0);
      idle(6);

      // Reset mid-WAIT with cnt=10: aborts silently and clears the pointer.
      plan_dly = 0;
      req = 4'b0100;
      step();
      chk("t5_pre_grant", int'(grant), 4);
      idle(10);
      rst_n = 1'b0;
      step();
      chk("t5_busy", int'(busy), 0);
      chk("t5_no_done", int'(done), 0);
      rst_n = 1'b1;
      plan_dly = 3;
      req = 4'b1010;
      step();
      chk("t5_ptr_zero_grant", int'(grant), 2);
      req = 4'b0;
      idle(10);

      // Pointer wrap: a lone request at index 2 is granted with pointer 3.
      req = 4'b0100;
      step();
      chk("t6_first", int'(grant), 4);
      idle(10);
      req = 4'b0100;
      step();
      chk("t6_wrap_grant", int'(grant), 4);
      idle(10);
      req = 4'b1001;
      step();
      chk("t6_ptr3_grant", int'(grant), 8);
      idle(10);

      // Randomized traffic against the model.
      rnd_mode = 1;
      idle(3000);
      rnd_mode = 0;
      rst_n = 1'b1;
      req = 4'b0;
      idle(80);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
